// File: rtl/tx_os_generator_pkg.sv
// Shared LTSSM definitions for the TX ordered-set generator and the RX side.
// Substate encodings, ordered-set symbols and the TX FSM state type.
package tx_os_generator_pkg;

    localparam logic [3:0] SS_DETECT_QUIET  = 4'd0;
    localparam logic [3:0] SS_DETECT_ACTIVE = 4'd1;
    localparam logic [3:0] SS_POLL_ACTIVE   = 4'd2;
    localparam logic [3:0] SS_POLL_CFG      = 4'd3;
    localparam logic [3:0] SS_CFG_LW_START  = 4'd4;
    localparam logic [3:0] SS_CFG_LW_ACCEPT = 4'd5;
    localparam logic [3:0] SS_CFG_LN_WAIT   = 4'd6;
    localparam logic [3:0] SS_CFG_LN_ACCEPT = 4'd7;
    localparam logic [3:0] SS_CFG_COMPLETE  = 4'd8;
    localparam logic [3:0] SS_CFG_IDLE      = 4'd9;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h2A;
    localparam logic [7:0] TS2_ID = 8'h25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_LO,
        ST_SEND_HI,
        ST_DONE1
    } tx_state_t;

    function automatic logic [7:0] ts_sym(
        input logic [3:0] idx,
        input logic       ts2,
        input logic [7:0] link,
        input logic [7:0] lane,
        input logic [7:0] nfts,
        input logic [7:0] rate
    );
        case (idx)
            4'd0:    return COM;
            4'd1:    return link;
            4'd2:    return lane;
            4'd3:    return nfts;
            4'd4:    return rate;
            default: return ts2 ? TS2_ID : TS1_ID;
        endcase
    endfunction

endpackage

// File: rtl/tx_os_generator_ts_lane_interleaver.sv
// Maps lane-major 8-symbol vectors onto the byte-interleaved bus:
// symbol s of lane l lands at byte s*N+l; bytes beyond 8*N stay zero.
module ts_lane_interleaver #(
    parameter int MAX_LANES = 8
) (
    input  logic [MAX_LANES*64-1:0] lane_syms,
    input  logic [4:0]              lanes,
    output logic [MAX_LANES*64-1:0] bus
);

    always_comb begin
        bus = '0;
        for (int l = 0; l < MAX_LANES; l++) begin
            for (int s = 0; s < 8; s++) begin
                if (l < int'(lanes)) begin
                    bus[(s*int'(lanes)+l)*8 +: 8] = lane_syms[(l*8+s)*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/tx_os_generator.sv
// TX ordered-set generator: emits TS1/TS2/idle beats per LTSSM substate,
// counts accepted ordered sets and pulses finish at the substate target.
module tx_os_generator
    import tx_os_generator_pkg::*;
#(
    parameter int         MAX_LANES       = 8,
    parameter logic [7:0] N_FTS           = 8'hAA,
    parameter int         POLL_ACTIVE_CNT = 1024,
    parameter int         TS2_CNT         = 16,
    parameter int         TS1_CFG_CNT     = 2,
    parameter int         IDLE_CNT        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [3:0]              substate,
    input  logic [7:0]              linkNumber,
    input  logic [7:0]              rateid,
    input  logic [4:0]              numberOfDetectedLanes,
    input  logic                    readyFromLMC,
    output logic [MAX_LANES*64-1:0] data,
    output logic                    validToLMC,
    output logic                    finish
);

    tx_state_t   state_q, state_d;
    logic [3:0]  sub_q, psub_q, r_sub;
    logic [7:0]  link_q, plink_q, r_link;
    logic [7:0]  rate_q, prate_q, r_rate;
    logic [4:0]  lanes_q, planes_q, r_lanes, in_lanes;
    logic [10:0] cnt_q, target;
    logic        pend_q, hit_q, hit_d;
    logic        accept, req, r_detect, take, count_inc;
    logic        idle_sub, ts2, use_link, use_lane, hi;
    logic [7:0]  link_b;
    logic [MAX_LANES*64-1:0] lane_syms, bus;

    assign in_lanes = (int'(numberOfDetectedLanes) > MAX_LANES)
                    ? 5'(MAX_LANES) : numberOfDetectedLanes;

    // A fresh start wins over an older pending one at the same boundary.
    assign req      = start | pend_q;
    assign r_sub    = start ? substate   : psub_q;
    assign r_link   = start ? linkNumber : plink_q;
    assign r_rate   = start ? rateid     : prate_q;
    assign r_lanes  = start ? in_lanes   : planes_q;
    assign r_detect = (r_sub <= SS_DETECT_ACTIVE) || (r_sub > SS_CFG_IDLE)
                    || (r_lanes == 5'd0);

    assign idle_sub = (sub_q == SS_CFG_IDLE);
    assign ts2      = (sub_q == SS_POLL_CFG) || (sub_q == SS_CFG_COMPLETE);
    assign use_link = (sub_q >= SS_CFG_LW_START);
    assign use_lane = (sub_q >= SS_CFG_LN_WAIT);
    assign hi       = (state_q == ST_SEND_HI);
    assign link_b   = use_link ? link_q : PAD;
    assign accept   = validToLMC & readyFromLMC;

    always_comb begin
        case (sub_q)
            SS_POLL_ACTIVE:                   target = 11'(POLL_ACTIVE_CNT);
            SS_POLL_CFG, SS_CFG_COMPLETE:     target = 11'(TS2_CNT);
            SS_CFG_LW_START, SS_CFG_LW_ACCEPT,
            SS_CFG_LN_WAIT, SS_CFG_LN_ACCEPT: target = 11'(TS1_CFG_CNT);
            SS_CFG_IDLE:                      target = 11'(IDLE_CNT);
            default:                          target = 11'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        count_inc = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE1: begin
                state_d = ST_IDLE;
                take    = start;
            end
            ST_SEND_LO: begin
                if (accept) begin
                    if (idle_sub) begin
                        count_inc = 1'b1;
                        take      = req;
                    end else begin
                        state_d = ST_SEND_HI;
                    end
                end
            end
            ST_SEND_HI: begin
                if (accept) begin
                    count_inc = 1'b1;
                    take      = req;
                    state_d   = ST_SEND_LO;
                end
            end
        endcase
        if (take) state_d = r_detect ? ST_DONE1 : ST_SEND_LO;
        hit_d = count_inc && (cnt_q != target) && (cnt_q + 11'd1 == target);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sub_q    <= '0;
            link_q   <= '0;
            rate_q   <= '0;
            lanes_q  <= '0;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
            pend_q   <= 1'b0;
            psub_q   <= '0;
            plink_q  <= '0;
            prate_q  <= '0;
            planes_q <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            if (take) begin
                sub_q   <= r_sub;
                link_q  <= r_link;
                rate_q  <= r_rate;
                lanes_q <= r_lanes;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
            end else begin
                if (count_inc && cnt_q != target) cnt_q <= cnt_q + 11'd1;
                if (start) begin
                    pend_q   <= 1'b1;
                    psub_q   <= substate;
                    plink_q  <= linkNumber;
                    prate_q  <= rateid;
                    planes_q <= in_lanes;
                end
            end
        end
    end

    always_comb begin
        lane_syms = '0;
        for (int l = 0; l < MAX_LANES; l++) begin
            for (int s = 0; s < 8; s++) begin
                lane_syms[(l*8+s)*8 +: 8] = idle_sub ? 8'h00 :
                    ts_sym(4'(s + (hi ? 8 : 0)), ts2, link_b,
                           use_lane ? 8'(l) : PAD, N_FTS, rate_q);
            end
        end
    end

    ts_lane_interleaver #(.MAX_LANES(MAX_LANES)) u_ilv (
        .lane_syms (lane_syms),
        .lanes     (lanes_q),
        .bus       (bus)
    );

    assign validToLMC = (state_q == ST_SEND_LO) || (state_q == ST_SEND_HI);
    assign data       = validToLMC ? bus : '0;
    assign finish     = hit_q || (state_q == ST_DONE1);

endmodule

// File: tb/tb_tx_os_generator.sv
// Directed bench for tx_os_generator: formats, counts, stalls, restarts.
// Expected beats are written out by hand per scenario.
module tb_tx_os_generator;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   substate;
    logic [7:0]   linkNumber;
    logic [7:0]   rateid;
    logic [4:0]   numberOfDetectedLanes;
    logic         readyFromLMC;
    logic [511:0] data;
    logic         validToLMC;
    logic         finish;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tx_os_generator #(
        .MAX_LANES       (8),
        .N_FTS           (8'hAA),
        .POLL_ACTIVE_CNT (8),
        .TS2_CNT         (16),
        .TS1_CFG_CNT     (2),
        .IDLE_CNT        (16)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .substate              (substate),
        .linkNumber            (linkNumber),
        .rateid                (rateid),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .readyFromLMC          (readyFromLMC),
        .data                  (data),
        .validToLMC            (validToLMC),
        .finish                (finish)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        readyFromLMC = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic kick(input logic [3:0] sub, input logic [4:0] n,
                        input logic [7:0] link, input logic [7:0] rate);
        start = 1'b1;
        substate = sub;
        numberOfDetectedLanes = n;
        linkNumber = link;
        rateid = rate;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        substate = 4'd0;
        linkNumber = 8'h00;
        rateid = 8'h00;
        numberOfDetectedLanes = 5'd0;
        do_reset();
        checks++;
        if (data !== 512'd0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", data);
        end
        checks++;
        if (validToLMC !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", validToLMC);
        end
        checks++;
        if (finish !== 1'b0) begin
            errors++;
            $display("FAIL reset_finish got %b want 0", finish);
        end
    endtask

    task automatic test_detect();
        logic [3:0] subs [3];
        logic [4:0] ns [3];
        subs[0] = 4'd0; ns[0] = 5'd2;
        subs[1] = 4'd12; ns[1] = 5'd4;
        subs[2] = 4'd2; ns[2] = 5'd0;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            kick(subs[i], ns[i], 8'h00, 8'h00);
            checks++;
            if (finish !== 1'b1 || validToLMC !== 1'b0) begin
                errors++;
                $display("FAIL detect_pulse%0d finish=%b valid=%b want 1 0",
                         i, finish, validToLMC);
            end
            step();
            checks++;
            if (finish !== 1'b0 || validToLMC !== 1'b0) begin
                errors++;
                $display("FAIL detect_after%0d finish=%b valid=%b want 0 0",
                         i, finish, validToLMC);
            end
        end
    endtask

    task automatic test_poll_active();
        logic [127:0] lo;
        logic [127:0] hi;
        int fin_at;
        int fin_cnt;
        lo = 128'h2A2A2A2A2A2A_AAAA_AAAA_F7F7_F7F7_BCBC;
        hi = {16{8'h2A}};
        do_reset();
        readyFromLMC = 1'b1;
        kick(4'd2, 5'd2, 8'h00, 8'hAA);
        checks++;
        if (validToLMC !== 1'b1 || data[127:0] !== lo) begin
            errors++;
            $display("FAIL poll_lo valid=%b data=%h want 1 %h",
                     validToLMC, data[127:0], lo);
        end
        checks++;
        if (data[511:128] !== '0) begin
            errors++;
            $display("FAIL poll_upper got %h want 0", data[511:128]);
        end
        step();
        checks++;
        if (data[127:0] !== hi) begin
            errors++;
            $display("FAIL poll_hi got %h want %h", data[127:0], hi);
        end
        fin_at = 0;
        fin_cnt = 0;
        for (int k = 2; k <= 18; k++) begin
            if (finish === 1'b1) begin
                fin_cnt++;
                fin_at = k;
            end
            if (k == 17) begin
                checks++;
                if (validToLMC !== 1'b1 || data[127:0] !== lo) begin
                    errors++;
                    $display("FAIL poll_repeat valid=%b data=%h want 1 %h",
                             validToLMC, data[127:0], lo);
                end
            end
            if (k < 18) step();
        end
        checks++;
        if (fin_cnt != 1 || fin_at != 17) begin
            errors++;
            $display("FAIL poll_finish count=%0d at=%0d want 1 at 17",
                     fin_cnt, fin_at);
        end
    endtask

    task automatic test_lanenum();
        logic [127:0] lo;
        int fin_at;
        lo = {{6{8'h2A}}, 8'h11, 8'h11, 8'hAA, 8'hAA,
              8'h01, 8'h00, 8'hBB, 8'hBB, 8'hBC, 8'hBC};
        do_reset();
        readyFromLMC = 1'b1;
        kick(4'd7, 5'd2, 8'hBB, 8'h11);
        checks++;
        if (data[127:0] !== lo) begin
            errors++;
            $display("FAIL lanenum_lo got %h want %h", data[127:0], lo);
        end
        fin_at = 0;
        for (int k = 1; k <= 6; k++) begin
            if (finish === 1'b1 && fin_at == 0) fin_at = k;
            step();
        end
        checks++;
        if (fin_at != 5) begin
            errors++;
            $display("FAIL lanenum_finish at=%0d want 5", fin_at);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] lo;
        logic [127:0] hi;
        logic [3:0]   pat;
        logic [511:0] prev;
        logic         fire;
        logic         exp_fin;
        int acc;
        int fin_cnt;
        int cyc;
        lo = {{6{8'h25}}, 8'h22, 8'h22, 8'hAA, 8'hAA,
              8'h01, 8'h00, 8'h05, 8'h05, 8'hBC, 8'hBC};
        hi = {16{8'h25}};
        pat = 4'b1001;
        do_reset();
        kick(4'd8, 5'd2, 8'h05, 8'h22);
        acc = 0;
        fin_cnt = 0;
        fire = 1'b0;
        cyc = 0;
        prev = data;
        while (acc < 34 && cyc < 200) begin
            exp_fin = fire && (acc == 32);
            if (finish === 1'b1) fin_cnt++;
            checks++;
            if (finish !== exp_fin) begin
                errors++;
                $display("FAIL bp_finish acc=%0d got %b want %b",
                         acc, finish, exp_fin);
            end
            checks++;
            if (validToLMC !== 1'b1 ||
                data[127:0] !== ((acc % 2 == 0) ? lo : hi)) begin
                errors++;
                $display("FAIL bp_beat acc=%0d valid=%b data=%h",
                         acc, validToLMC, data[127:0]);
            end
            if (!fire && cyc > 0) begin
                checks++;
                if (data !== prev) begin
                    errors++;
                    $display("FAIL bp_hold got %h want %h",
                             data[127:0], prev[127:0]);
                end
            end
            prev = data;
            readyFromLMC = pat[3 - (cyc % 4)];
            fire = readyFromLMC;
            step();
            if (fire) acc++;
            cyc++;
        end
        checks++;
        if (fin_cnt != 1 || acc < 34) begin
            errors++;
            $display("FAIL bp_total finishes=%0d beats=%0d want 1 34",
                     fin_cnt, acc);
        end
    endtask

    task automatic test_start_mid();
        logic [127:0] lo_old;
        logic [127:0] lo_new;
        logic [127:0] hi;
        int fin_at;
        lo_old = 128'h2A2A2A2A2A2A_AAAA_AAAA_F7F7_F7F7_BCBC;
        lo_new = {{6{8'h2A}}, 8'hAA, 8'hAA, 8'hAA, 8'hAA,
                  8'hF7, 8'hF7, 8'h3C, 8'h3C, 8'hBC, 8'hBC};
        hi = {16{8'h2A}};
        do_reset();
        kick(4'd2, 5'd2, 8'h00, 8'hAA);
        kick(4'd5, 5'd2, 8'h3C, 8'hAA);
        checks++;
        if (data[127:0] !== lo_old) begin
            errors++;
            $display("FAIL mid_lo_hold got %h want %h", data[127:0], lo_old);
        end
        readyFromLMC = 1'b1;
        step();
        checks++;
        if (data[127:0] !== hi) begin
            errors++;
            $display("FAIL mid_hi got %h want %h", data[127:0], hi);
        end
        step();
        checks++;
        if (data[127:0] !== lo_new) begin
            errors++;
            $display("FAIL mid_new_lo got %h want %h", data[127:0], lo_new);
        end
        fin_at = 0;
        for (int k = 4; k <= 9; k++) begin
            if (finish === 1'b1 && fin_at == 0) fin_at = k;
            step();
        end
        checks++;
        if (fin_at != 8) begin
            errors++;
            $display("FAIL mid_finish at=%0d want 8", fin_at);
        end
    endtask

    task automatic test_cfg_idle();
        int fin_at;
        do_reset();
        readyFromLMC = 1'b1;
        kick(4'd9, 5'd1, 8'h00, 8'h00);
        checks++;
        if (validToLMC !== 1'b1 || data !== 512'd0) begin
            errors++;
            $display("FAIL idle_beat valid=%b data=%h want 1 0",
                     validToLMC, data[127:0]);
        end
        fin_at = 0;
        for (int k = 1; k <= 19; k++) begin
            if (finish === 1'b1 && fin_at == 0) fin_at = k;
            step();
        end
        checks++;
        if (fin_at != 17) begin
            errors++;
            $display("FAIL idle_finish at=%0d want 17", fin_at);
        end
    endtask

    task automatic test_clamp_reset();
        logic [511:0] lo;
        logic [511:0] hi;
        lo = {{24{8'h2A}}, {8{8'h77}}, {8{8'hAA}}, {16{8'hF7}}, {8{8'hBC}}};
        hi = {64{8'h2A}};
        do_reset();
        readyFromLMC = 1'b1;
        kick(4'd2, 5'd12, 8'h00, 8'h77);
        checks++;
        if (data !== lo) begin
            errors++;
            $display("FAIL clamp_lo got %h want %h", data, lo);
        end
        step();
        checks++;
        if (data !== hi) begin
            errors++;
            $display("FAIL clamp_hi got %h want %h", data, hi);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (validToLMC !== 1'b0 || data !== 512'd0 || finish !== 1'b0) begin
            errors++;
            $display("FAIL midreset valid=%b finish=%b data=%h want 0 0 0",
                     validToLMC, finish, data[127:0]);
        end
        step();
        checks++;
        if (validToLMC !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle valid=%b want 0", validToLMC);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        readyFromLMC = 1'b0;
        test_reset();
        test_detect();
        test_poll_active();
        test_lanenum();
        test_backpressure();
        test_start_mid();
        test_cfg_idle();
        test_clamp_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_os_generator.md
Name: tx_os_generator

Overview:
- Transmit-side ordered-set generator. It produces the TS1 and TS2 training sequences, and the idle data, that the TX LTSSM has to send in each substate.
- It is the counterpart of the RX ordered-set decoder and the RX LTSSM: it drives byte-interleaved multi-lane data toward the lane management controller (LMC).
- It counts the complete ordered sets the LMC accepts and pulses finish when the substate's minimum transmit count is met.

Parameters:
- MAX_LANES, 8, max lanes carried on the 512-bit bus (8 lanes x 8 symbols x 8 bits).
- N_FTS, 8'hAA, value placed in symbol 3 of every TS.
- POLL_ACTIVE_CNT, 1024, TS1s required in pollingActive before finish.
- TS2_CNT, 16, TS2s required in pollingConfiguration and configurationComplete before finish.
- TS1_CFG_CNT, 2, TS1s required in the configuration TS1 substates before finish.
- IDLE_CNT, 16, idle-data beats required in configurationIdle before finish.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle strobe; latches substate, linkNumber, rateid, numberOfDetectedLanes.
- substate  in  4  LTSSM substate encoding: 0 detectQuiet … 9 configurationIdle.
- linkNumber  in  8  link number for the configuration substates.
- rateid  in  8  data-rate identifier placed in symbol 4.
- numberOfDetectedLanes  in  5  active lanes; valid 1..MAX_LANES.
- readyFromLMC  in  1  LMC accepts the current beat when validToLMC && readyFromLMC.
- data  out  512  TX beat, byte-interleaved.
- validToLMC  out  1  data valid.
- finish  out  1  one-cycle pulse when the required count is met.

Behaviour:
- Reset values:
  - data=0, validToLMC=0, finish=0.
  - FSM=IDLE, counters=0.
- Beat format:
  - Each beat carries 8 symbols per lane. Symbol s (0..7) of lane l sits at byte index s*N+l, where N = latched lane count.
  - Bytes at index ≥ 8*N are zero.
  - A TS spans 2 beats: LO = symbols 0-7, HI = symbols 8-15.
- TS symbols:
  - sym0 = 8'hBC (COM).
  - sym1 = link: 8'hF7 (PAD) or linkNumber.
  - sym2 = lane: 8'hF7 or the lane index l.
  - sym3 = N_FTS.
  - sym4 = rateid.
  - sym5-15 = identifier: TS1 8'h2A, TS2 8'h25. These are the same identifier values the RX decoder matches.
- Per-substate content:
  - detectQuiet, detectActive: nothing sent; finish pulses in the cycle after start.
  - pollingActive: TS1, link PAD, lane PAD; POLL_ACTIVE_CNT.
  - pollingConfiguration: TS2, link PAD, lane PAD; TS2_CNT.
  - configurationLinkWidthStart, configurationLinkWidthAccept: TS1, link=linkNumber, lane PAD; TS1_CFG_CNT.
  - configurationLanenumWait, configurationLanenumAccept: TS1, link=linkNumber, lane=l; TS1_CFG_CNT.
  - configurationComplete: TS2, link=linkNumber, lane=l; TS2_CNT.
  - configurationIdle: all-zero beats with validToLMC=1, each beat counted; IDLE_CNT.
  - Encodings 10-15: treated as detectQuiet.
- FSM states and transitions:
  - IDLE: on start with a detect substate, go to DONE1; on start with any other substate, go to SEND_LO.
  - SEND_LO: on accept, go to SEND_HI.
  - SEND_HI: on accept, increment the TS count and go to SEND_LO.
  - DONE1: pulses finish, then returns to IDLE.
- Latency: start at cycle t gives validToLMC=1 with the LO beat registered at t+1.
- Backpressure: while readyFromLMC=0, data and validToLMC hold stable. No symbol is skipped or repeated.
- Counting and finish:
  - The count is 11 bits and saturates at its target.
  - finish pulses exactly once, in the cycle after the accept that reaches the target.
  - Transmission then continues, repeating the same OS, until the next start.
- Start while sending:
  - A start during SEND_LO or SEND_HI takes effect only at a TS boundary, i.e. after HI is accepted, so a TS is never truncated.
  - The new parameters are latched at that boundary and the count clears.
  - A second start before that boundary overwrites the pending one.
- reset mid-operation: immediate return to reset values. No partial TS completes.
- Lane count clamping:
  - numberOfDetectedLanes > MAX_LANES is clamped to MAX_LANES.
  - 0 is treated as detect: nothing is sent and finish pulses.

Decomposition:
- Shared package holds:
  - substate localparams 0..9;
  - COM 8'hBC, PAD 8'hF7, TS1_ID 8'h2A, TS2_ID 8'h25.
  - The RX decoder and RX LTSSM use the same package.
- One sub-module, ts_lane_interleaver: combinational mapping of a per-lane 8-symbol vector plus N into the 512-bit bus.

Test Plan:
- Reset, then start with substate=0 → validToLMC stays 0; finish=1 exactly one cycle after start.
- N=2, substate=2, ready=1, POLL_ACTIVE_CNT=8:
  - first beat data[127:0] = 128'h2A2A2A2A2A2A_AAAA_AAAA_F7F7_F7F7_BCBC with rateid=8'hAA;
  - next beat is all 8'h2A in the low 16 bytes;
  - finish pulses after the 16th accepted beat.
- N=2, substate=7, linkNumber=8'hBB → sym1 lanes 0/1 = BB BB, sym2 = 00 01; finish after 4 accepted beats.
- Toggle readyFromLMC 1,0,0,1 during substate=8 → data and valid held through the stall; exactly 16 TS2s counted before finish; no symbol loss.
- Start substate=5 mid-LO beat of a substate=2 TS → HI beat still TS1 PAD; next LO beat carries link=linkNumber; count restarts at 0.
- numberOfDetectedLanes=12 → behaves as 8 lanes, all 64 bytes populated; assert reset during SEND_HI → next cycle validToLMC=0 and data=0.
